eda_window_scanner: RTL and testbench

//  Read-side initiator for eda_img_ram. After the image is loaded, it walks center_addr over every pixel in

---
 rtl/eda_img_pkg.sv | 28 ++
 rtl/eda_window_max_cmp.sv | 27 ++
 rtl/eda_window_scanner.sv | 140 ++++++++++++++
 tb/tb_eda_window_scanner.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eda_img_pkg.sv
// Shared types and constants for the image window scanner and its compare helper.
// Window slice s occupies bits [s*PIXEL_WIDTH +: PIXEL_WIDTH]; slice 8 is upleft, slice 0 is downright.
package eda_img_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } scan_state_e;

    localparam int UPLEFT    = 7;
    localparam int UP        = 6;
    localparam int UPRIGHT   = 5;
    localparam int LEFT      = 4;
    localparam int RIGHT     = 3;
    localparam int DOWNLEFT  = 2;
    localparam int DOWN      = 1;
    localparam int DOWNRIGHT = 0;

    localparam int CENTER_IDX = 4;

    // The mask skips the center, so mask bits at or above the center shift up one slice.
    function automatic int neigh_slice(input int bit_idx);
        return (bit_idx >= CENTER_IDX) ? bit_idx + 1 : bit_idx;
    endfunction

endpackage

// File: rtl/eda_window_max_cmp.sv
// Combinational local-maximum test: center >= every neighbour whose mask bit is set.
module eda_window_max_cmp
    import eda_img_pkg::*;
#(
    parameter int PIXEL_WIDTH  = 8,
    parameter int WINDOW_WIDTH = 9
) (
    input  logic [PIXEL_WIDTH*WINDOW_WIDTH-1:0] window,
    input  logic [WINDOW_WIDTH-2:0]             mask,
    output logic                                is_max
);

    logic [PIXEL_WIDTH-1:0] center;

    assign center = window[CENTER_IDX*PIXEL_WIDTH +: PIXEL_WIDTH];

    // Plateaus count as maxima, so only a strictly larger valid neighbour disqualifies.
    always_comb begin
        is_max = 1'b1;
        for (int b = 0; b < WINDOW_WIDTH - 1; b++) begin
            if (mask[b] && (window[neigh_slice(b)*PIXEL_WIDTH +: PIXEL_WIDTH] > center)) begin
                is_max = 1'b0;
            end
        end
    end

endmodule

// File: rtl/eda_window_scanner.sv
// Raster-order read initiator for the image RAM: walks center_addr over every pixel and
// streams one registered window/mask/local-max beat per pixel over valid/ready.
module eda_window_scanner
    import eda_img_pkg::*;
#(
    parameter int M            = 16,
    parameter int N            = 16,
    parameter int PIXEL_WIDTH  = 8,
    parameter int WINDOW_WIDTH = 9,
    parameter int I_WIDTH      = $clog2(N),
    parameter int J_WIDTH      = $clog2(M),
    parameter int ADDR_WIDTH   = I_WIDTH + J_WIDTH
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                start,
    output logic                                busy,
    output logic                                done,
    output logic [ADDR_WIDTH-1:0]               center_addr,
    input  logic [PIXEL_WIDTH*WINDOW_WIDTH-1:0] window_values,
    input  logic [WINDOW_WIDTH-2:0]             neigh_valid,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [ADDR_WIDTH-1:0]               out_addr,
    output logic [PIXEL_WIDTH*WINDOW_WIDTH-1:0] out_window,
    output logic [WINDOW_WIDTH-2:0]             out_mask,
    output logic                                out_is_max,
    output logic                                out_last
);

    scan_state_e state;
    scan_state_e state_next;

    logic [I_WIDTH-1:0] row_i;
    logic [J_WIDTH-1:0] col_j;

    logic ld;
    logic hs;
    logic at_last_col;
    logic at_last_row;
    logic win_is_max;

    assign center_addr = {row_i, col_j};
    assign at_last_col = (col_j == J_WIDTH'(M - 1));
    assign at_last_row = (row_i == I_WIDTH'(N - 1));
    assign hs          = out_valid && out_ready;
    // A new beat may enter the output register whenever it is empty or being drained this cycle.
    assign ld          = (state == SCAN) && (!out_valid || out_ready);

    eda_window_max_cmp #(
        .PIXEL_WIDTH  (PIXEL_WIDTH),
        .WINDOW_WIDTH (WINDOW_WIDTH)
    ) u_max_cmp (
        .window (window_values),
        .mask   (neigh_valid),
        .is_max (win_is_max)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (ld && at_last_col && at_last_row) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (hs) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Raster counters wrap explicitly so non-power-of-two image sizes work.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            row_i <= '0;
            col_j <= '0;
        end else if (state == IDLE && start) begin
            row_i <= '0;
            col_j <= '0;
        end else if (ld) begin
            if (at_last_col) begin
                col_j <= '0;
                if (at_last_row) begin
                    row_i <= '0;
                end else begin
                    row_i <= row_i + I_WIDTH'(1);
                end
            end else begin
                col_j <= col_j + J_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid  <= 1'b0;
            out_addr   <= '0;
            out_window <= '0;
            out_mask   <= '0;
            out_is_max <= 1'b0;
            out_last   <= 1'b0;
        end else if (ld) begin
            out_valid  <= 1'b1;
            out_addr   <= center_addr;
            out_window <= window_values;
            out_mask   <= neigh_valid;
            out_is_max <= win_is_max;
            out_last   <= at_last_col && at_last_row;
        end else if (hs) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_eda_window_scanner.sv
// Scoreboard bench for eda_window_scanner on a 4x4 image with a behavioural image RAM.
module tb_eda_window_scanner;

    localparam int M  = 4;
    localparam int N  = 4;
    localparam int PW = 8;
    localparam int WW = 9;
    localparam int AW = 4;

    logic            clk;
    logic            reset_n;
    logic            start;
    logic            busy;
    logic            done;
    logic [AW-1:0]   center_addr;
    logic [PW*WW-1:0] window_values;
    logic [WW-2:0]   neigh_valid;
    logic            out_valid;
    logic            out_ready;
    logic [AW-1:0]   out_addr;
    logic [PW*WW-1:0] out_window;
    logic [WW-2:0]   out_mask;
    logic            out_is_max;
    logic            out_last;

    eda_window_scanner #(
        .M            (M),
        .N            (N),
        .PIXEL_WIDTH  (PW),
        .WINDOW_WIDTH (WW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .center_addr   (center_addr),
        .window_values (window_values),
        .neigh_valid   (neigh_valid),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_addr      (out_addr),
        .out_window    (out_window),
        .out_mask      (out_mask),
        .out_is_max    (out_is_max),
        .out_last      (out_last)
    );

    typedef struct {
        logic [3:0]  addr;
        logic [71:0] win;
        logic [7:0]  mask;
        logic        is_max;
        logic        last;
    } sb_entry_t;

    logic [7:0] img [16];
    sb_entry_t  sb [$];
    sb_entry_t  mon_e;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int last_cyc = 0;
    int prev_cyc = 0;
    bit seen_beat = 0;
    bit b2b       = 0;
    bit peak_mode = 0;
    bit flat_mode = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Flat index of the pixel under window slice s around addr, or -1 if off the image.
    function automatic int nb_idx(input int addr, input int s);
        int ni;
        int nj;
        ni = addr / 4 + (8 - s) / 3 - 1;
        nj = addr % 4 + (8 - s) % 3 - 1;
        if (ni < 0 || ni > 3 || nj < 0 || nj > 3) return -1;
        return ni * 4 + nj;
    endfunction

    always_comb begin
        window_values = '0;
        neigh_valid   = '0;
        for (int s = 0; s < 9; s++) begin
            if (nb_idx(int'(center_addr), s) >= 0) begin
                window_values[s*8 +: 8] = img[nb_idx(int'(center_addr), s)];
                if (s != 4) neigh_valid[(s > 4) ? s - 1 : s] = 1'b1;
            end
        end
    end

    function automatic logic [71:0] exp_win(input int addr);
        logic [71:0] w;
        w = '0;
        for (int s = 0; s < 9; s++)
            if (nb_idx(addr, s) >= 0) w[s*8 +: 8] = img[nb_idx(addr, s)];
        return w;
    endfunction

    function automatic logic [7:0] exp_mask(input int addr);
        logic [7:0] m;
        m = '0;
        for (int s = 0; s < 9; s++)
            if (s != 4 && nb_idx(addr, s) >= 0) m[(s > 4) ? s - 1 : s] = 1'b1;
        return m;
    endfunction

    function automatic logic exp_max(input int addr);
        for (int s = 0; s < 9; s++)
            if (s != 4 && nb_idx(addr, s) >= 0 && img[nb_idx(addr, s)] > img[addr]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit is_peak_nbr(input int a);
        return (a == 0 || a == 1 || a == 2 || a == 4 || a == 6 || a == 8 || a == 9 || a == 10);
    endfunction

    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check_val("unexpected_beat", 72'(out_addr), 72'hFFFF);
            end else begin
                mon_e = sb.pop_front();
                check_val("beat_addr",   72'(out_addr),   72'(mon_e.addr));
                check_val("beat_window", out_window,      mon_e.win);
                check_val("beat_mask",   72'(out_mask),   72'(mon_e.mask));
                check_val("beat_is_max", 72'(out_is_max), 72'(mon_e.is_max));
                check_val("beat_last",   72'(out_last),   72'(mon_e.last));
                case (out_addr)
                    4'd0:  check_val("corner_mask_0",  72'(out_mask), 72'(8'b00001011));
                    4'd3:  check_val("corner_mask_3",  72'(out_mask), 72'(8'b00010110));
                    4'd15: check_val("corner_mask_15", 72'(out_mask), 72'(8'b11010000));
                    4'd5:  check_val("inner_mask_5",   72'(out_mask), 72'(8'hFF));
                    default: ;
                endcase
                if (peak_mode)
                    check_val("peak_is_max", 72'(out_is_max), 72'(!is_peak_nbr(int'(out_addr))));
                if (flat_mode)
                    check_val("plateau_is_max", 72'(out_is_max), 72'(1));
                if (b2b && seen_beat)
                    check_val("beat_gap", 72'(cyc - prev_cyc), 72'(1));
                seen_beat = 1;
                prev_cyc  = cyc;
                if (out_last) last_cyc = cyc;
            end
        end
        if (reset_n && done) begin
            done_cnt++;
            check_val("done_latency", 72'(cyc - last_cyc), 72'(1));
        end
    end

    task automatic push_all();
        sb_entry_t e;
        for (int k = 0; k < 16; k++) begin
            e.addr   = 4'(k);
            e.win    = exp_win(k);
            e.mask   = exp_mask(k);
            e.is_max = exp_max(k);
            e.last   = (k == 15);
            sb.push_back(e);
        end
        seen_beat = 0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check_val("scan_busy",       72'(busy),        72'(1));
        check_val("scan_first_addr", 72'(center_addr), 72'(0));
        check_val("scan_no_beat",    72'(out_valid),   72'(0));
    endtask

    task automatic wait_done(input int budget);
        int d0;
        int k;
        d0 = done_cnt;
        k  = 0;
        while (done_cnt == d0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        check_val("done_timeout", 72'(done_cnt == d0), 72'(0));
        repeat (3) @(posedge clk);
        #1;
        check_val("done_pulses",  72'(done_cnt - d0), 72'(1));
        check_val("beats_left",   72'(sb.size()),     72'(0));
        check_val("idle_busy",    72'(busy),          72'(0));
        check_val("idle_center",  72'(center_addr),   72'(0));
    endtask

    task automatic wait_beat(input int addr, output bit found);
        found = 0;
        for (int k = 0; k < 60 && !found; k++) begin
            @(posedge clk); #1;
            if (out_valid && out_addr == 4'(addr)) found = 1;
        end
        check_val("find_beat", 72'(found), 72'(1));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        reset_n   = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) img[k] = 8'(k);
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy",      72'(busy),        72'(0));
        check_val("rst_done",      72'(done),        72'(0));
        check_val("rst_out_valid", 72'(out_valid),   72'(0));
        check_val("rst_center",    72'(center_addr), 72'(0));
        check_val("rst_out_addr",  72'(out_addr),    72'(0));
        check_val("rst_out_win",   out_window,       72'(0));
        check_val("rst_out_mask",  72'(out_mask),    72'(0));
        check_val("rst_out_max",   72'(out_is_max),  72'(0));
        check_val("rst_out_last",  72'(out_last),    72'(0));
        reset_n = 1'b1;

        // ramp image, streaming back-to-back
        b2b = 1;
        push_all();
        pulse_start();
        wait_done(200);

        // single peak at addr 5
        for (int k = 0; k < 16; k++) img[k] = 8'd10;
        img[5]    = 8'd50;
        peak_mode = 1;
        push_all();
        pulse_start();
        wait_done(200);
        peak_mode = 0;

        // plateau
        img[5]    = 8'd10;
        flat_mode = 1;
        push_all();
        pulse_start();
        wait_done(200);
        flat_mode = 0;

        // backpressure at beat 6
        for (int k = 0; k < 16; k++) img[k] = 8'(k * 13 + 7);
        b2b = 0;
        push_all();
        pulse_start();
        wait_beat(6, found);
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check_val("stall_valid",  72'(out_valid),   72'(1));
            check_val("stall_addr",   72'(out_addr),    72'(6));
            check_val("stall_center", 72'(center_addr), 72'(7));
        end
        out_ready = 1'b1;
        wait_done(200);

        // start pulse during SCAN must be ignored
        for (int k = 0; k < 16; k++) img[k] = 8'(k);
        b2b = 1;
        push_all();
        pulse_start();
        wait_beat(4, found);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(200);

        // reset in the middle of the stream, then a clean rescan
        push_all();
        pulse_start();
        wait_beat(8, found);
        reset_n = 1'b0;
        @(posedge clk); #1;
        check_val("midrst_valid",  72'(out_valid),   72'(0));
        check_val("midrst_busy",   72'(busy),        72'(0));
        check_val("midrst_center", 72'(center_addr), 72'(0));
        reset_n = 1'b1;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        check_val("midrst_idle_valid", 72'(out_valid), 72'(0));
        push_all();
        pulse_start();
        wait_done(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
